ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter for the keyboard port; sends command bytes to the keyboard (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable). It follows the standard host-request sequence: inhibit, request-to-send, device-clocked bit shifting, ACK check, bus-idle wait. It shares the PS2_CLK/PS2_DAT open-drain lines with the PS/2 receiver/parser. While the bus is owned, it asserts rx_inhibit so the receiver ignores its own traffic.

Parameters:
INHIBIT_CYCLES, 6000, CLOCK_50 cycles PS2_CLK is held low before request (120 us at 50 MHz)
START_TIMEOUT, 750000, max cycles from clock release to first device falling edge (15 ms)
XFER_TIMEOUT, 100000, max cycles from first falling edge to ACK sample (2 ms)
SYNC_STAGES, 2, synchronizer depth on PS2_CLK/PS2_DAT inputs

Ports:
CLOCK_50  input  1  system clock; only clock in the block
reset  input  1  asynchronous, active-low reset
tx_data  input  8  command byte to send
tx_valid  input  1  request; byte accepted when tx_valid && tx_ready
tx_ready  output  1  high only in IDLE
done  output  1  one-cycle pulse at end of every accepted transfer
err  output  2  valid with done: 00 ok, 01 start timeout, 10 transfer timeout, 11 no ACK
rx_inhibit  output  1  high in every state except IDLE
PS2_CLK  inout  1  open-drain: drives 0 or z, never 1
PS2_DAT  inout  1  open-drain: drives 0 or z, never 1

Behaviour:
- Reset (reset=0, async): state IDLE, both lines z, tx_ready=1, done=0, err=00, rx_inhibit=0, counters and shift register cleared.
- Inputs pass through SYNC_STAGES flops. fall = synchronized clk was 1 last cycle and is 0 this cycle.
- IDLE: tx_ready=1. On accept, latch tx_data and parity = ~^tx_data (odd parity), clear the counter, go INHIBIT next cycle. tx_valid in any other state is ignored.
- INHIBIT: drive PS2_CLK=0, PS2_DAT=z. After INHIBIT_CYCLES cycles, drive PS2_DAT=0 and go REQ.
- REQ: release PS2_CLK (z), keep PS2_DAT=0, count cycles. If a fall occurs, drive bit0 on PS2_DAT, set bit index to 1, go DATA. If the count reaches START_TIMEOUT first, go FINISH with err=01.
- DATA: on each fall, drive the next bit, LSB first (1 = z, 0 = drive 0). The fall after bit7 is driven drives parity and goes PARITY.
- PARITY: on the next fall, release PS2_DAT (stop bit) and go ACK.
- ACK: on the next fall, sample synchronized PS2_DAT. 0 gives err=00 and goes WAIT_IDLE. 1 gives err=11 and goes WAIT_IDLE.
- Fall count per transfer: 11 falls. Falls 1-8 drive data bits, fall 9 drives parity, fall 10 releases for stop, fall 11 samples ACK.
- WAIT_IDLE: both lines z. Wait until synchronized clk=1 and dat=1 for one cycle, then go FINISH.
- FINISH: done=1 for exactly one cycle with err held, then IDLE. err holds its value until the next accept; it clears to 00 on accept.
- Transfer timer: starts at the first fall and runs through DATA, PARITY, ACK and WAIT_IDLE. Reaching XFER_TIMEOUT releases both lines and goes FINISH with err=10; this has priority over any same-cycle fall.
- Timeout or error never leaves any line driven. Every accepted byte produces exactly one done pulse.
- Falls seen in INHIBIT (self-driven) are ignored.
- Reset mid-transfer releases the lines immediately, asynchronously; no done pulse is produced.

Decomposition:
- Shared package ps2_pkg: state enum (IDLE, INHIBIT, REQ, DATA, PARITY, ACK, WAIT_IDLE, FINISH); err codes (ERR_OK, ERR_START_TO, ERR_XFER_TO, ERR_NO_ACK); command constants (CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RESP_ACK=8'hFA).
- Sub-module ps2_line_sync: synchronizer plus falling-edge detect on PS2_CLK, with the synchronized PS2_DAT. The receiver reuses it.

Test Plan:
- INHIBIT_CYCLES=20. Send 0xED; device model clocks 11 falls and ACKs. Bits seen on device rising edges: 0 (start), then 1,0,1,1,0,1,1,1, parity 1, stop 1. Response: done with err=00. PS2_CLK low exactly 20 cycles before request.
- Send 0x00 -> parity 1. Send 0x01 -> parity 0. Both done with err=00, tx_ready returns 1 in the cycle after done.
- Device never clocks, START_TIMEOUT=100 -> done at +100 cycles after REQ with err=01, both lines z, rx_inhibit deasserts next cycle.
- Device stops after 5 falls, XFER_TIMEOUT=200 -> done with err=10, both lines z.
- Device leaves data high on fall 11 -> done with err=11. An immediate re-send of 0xFF succeeds with err=00.
- Assert reset during DATA at fall 4 -> lines z in the same cycle, no done pulse, tx_ready=1 after release. Also: tx_valid held during a transfer is not accepted until IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, completion codes,
// well-known keyboard command bytes and a counter sizing helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        ACK       = 3'd5,
        WAIT_IDLE = 3'd6,
        FINISH    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_START_TO = 2'b01,
        ERR_XFER_TO  = 2'b10,
        ERR_NO_ACK   = 2'b11
    } err_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    // Bits needed for one counter that must reach (largest limit - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the PS2_CLK / PS2_DAT lines into the system clock domain and
// flags a falling edge of the synchronized clock. Shared with the receiver.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_s_o,
    output logic dat_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage samples the raw bus; an idle bus reads high.
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        clk_sync_q[gi] <= 1'b1;
                        dat_sync_q[gi] <= 1'b1;
                    end else begin
                        clk_sync_q[gi] <= ps2_clk_i;
                        dat_sync_q[gi] <= ps2_dat_i;
                    end
                end
            end else begin : g_next
                // Later stages shift the previous stage along.
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        clk_sync_q[gi] <= 1'b1;
                        dat_sync_q[gi] <= 1'b1;
                    end else begin
                        clk_sync_q[gi] <= clk_sync_q[gi-1];
                        dat_sync_q[gi] <= dat_sync_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // One-cycle-old copy of the synchronized clock for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) clk_prev_q <= 1'b1;
        else         clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end

    assign clk_s_o = clk_sync_q[SYNC_STAGES-1];
    assign dat_s_o = dat_sync_q[SYNC_STAGES-1];
    assign fall_o  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// shifting of data/parity/stop, ACK check and bus-idle wait. Lines are
// open-drain (0 or z) and are released on every exit path.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic [1:0] err,
    output logic       rx_inhibit,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    // One counter serves inhibit, start wait and transfer timer in turn.
    localparam int CNT_W = cnt_width(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);

    state_t           state_q;
    err_t             err_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [3:0]       bit_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_drv_q;
    logic             dat_drv_q;
    logic             tx_ready_q;
    logic             done_q;
    logic             rx_inhibit_q;

    logic clk_s;
    logic dat_s;
    logic clk_fall;
    logic xfer_to;

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i    (CLOCK_50),
        .rst_ni   (reset),
        .ps2_clk_i(PS2_CLK),
        .ps2_dat_i(PS2_DAT),
        .clk_s_o  (clk_s),
        .dat_s_o  (dat_s),
        .fall_o   (clk_fall)
    );

    // Transfer timer expiry; it outranks any fall seen in the same cycle.
    assign xfer_to = (state_q inside {DATA, PARITY, ACK, WAIT_IDLE}) &&
                     (cnt_q == CNT_W'(XFER_TIMEOUT - 1));

    // Transmit FSM with registered line drivers and handshake outputs.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            err_q        <= ERR_OK;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            bit_idx_q    <= '0;
            cnt_q        <= '0;
            clk_drv_q    <= 1'b0;
            dat_drv_q    <= 1'b0;
            tx_ready_q   <= 1'b1;
            done_q       <= 1'b0;
            rx_inhibit_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (xfer_to) begin
                clk_drv_q <= 1'b0;
                dat_drv_q <= 1'b0;
                err_q     <= ERR_XFER_TO;
                done_q    <= 1'b1;
                state_q   <= FINISH;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tx_valid && tx_ready_q) begin
                            shift_q      <= tx_data;
                            parity_q     <= ~^tx_data;
                            cnt_q        <= '0;
                            bit_idx_q    <= '0;
                            err_q        <= ERR_OK;
                            tx_ready_q   <= 1'b0;
                            rx_inhibit_q <= 1'b1;
                            clk_drv_q    <= 1'b1;
                            state_q      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        // Our own low clock produces falls here; they are ignored.
                        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                            clk_drv_q <= 1'b0;
                            dat_drv_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= REQ;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    REQ: begin
                        if (clk_fall) begin
                            dat_drv_q <= ~shift_q[0];
                            bit_idx_q <= 4'd1;
                            cnt_q     <= '0;
                            state_q   <= DATA;
                        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                            dat_drv_q <= 1'b0;
                            err_q     <= ERR_START_TO;
                            done_q    <= 1'b1;
                            state_q   <= FINISH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (clk_fall) begin
                            if (bit_idx_q == 4'd8) begin
                                dat_drv_q <= ~parity_q;
                                state_q   <= PARITY;
                            end else begin
                                dat_drv_q <= ~shift_q[bit_idx_q[2:0]];
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (clk_fall) begin
                            dat_drv_q <= 1'b0;
                            state_q   <= ACK;
                        end
                    end
                    ACK: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (clk_fall) begin
                            err_q   <= dat_s ? ERR_NO_ACK : ERR_OK;
                            state_q <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (clk_s && dat_s) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                    FINISH: begin
                        clk_drv_q    <= 1'b0;
                        dat_drv_q    <= 1'b0;
                        tx_ready_q   <= 1'b1;
                        rx_inhibit_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign PS2_CLK    = clk_drv_q ? 1'b0 : 1'bz;
    assign PS2_DAT    = dat_drv_q ? 1'b0 : 1'bz;
    assign tx_ready   = tx_ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rx_inhibit = rx_inhibit_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: a PS/2 device model clocks the host, a scoreboard
// queue holds the expected completion of each accepted byte.
module tb_ps2_host_tx;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    wire        tx_ready;
    wire        done;
    wire  [1:0] err;
    wire        rx_inhibit;
    wire        ps2_clk;
    wire        ps2_dat;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic [10:0] dev_frame = '0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .START_TIMEOUT (100),
        .XFER_TIMEOUT  (200),
        .SYNC_STAGES   (2)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .err       (err),
        .rx_inhibit(rx_inhibit),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  err;
        bit          chk_frame;
        logic [10:0] frame;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Frame as seen by the device: start, d[0..7], parity (hand value), stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic p, input logic [1:0] e, input bit chkf);
        exp_t x;
        x.data = d;
        x.err = e;
        x.chk_frame = chkf;
        x.frame = mk_frame(d, p);
        exp_q.push_back(x);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("ready_wait", tx_ready, 1);
    endtask

    task automatic issue(input logic [7:0] d, input logic p, input logic [1:0] e, input bit chkf, input bit push);
        @(negedge CLOCK_50);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        if (push) push_exp(d, p, e, chkf);
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
    endtask

    // Device model: measures inhibit, then clocks nfalls falls (7 low / 7 high).
    task automatic dev_run(input int nfalls, input bit ack_low, input bit hold_last);
        int n;
        logic [10:0] fr;
        fr = '0;
        n = 0;
        while (ps2_clk !== 1'b0 && n < 500) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (ps2_clk !== 1'b0) begin
            chk("inhibit_seen", ps2_clk, 0);
            return;
        end
        n = 0;
        while (ps2_clk === 1'b0 && n < 500) begin
            n++;
            @(negedge CLOCK_50);
        end
        chk("inhibit_len", n, 20);
        chk("req_dat_low", ps2_dat, 0);
        if (nfalls == 0) begin
            n = 0;
            while (done !== 1'b1 && n < 500) begin
                @(negedge CLOCK_50);
                n++;
            end
            chk("start_to_latency", n, 100);
            return;
        end
        repeat (4) @(negedge CLOCK_50);
        fr[0] = ps2_dat;
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk_low = 1'b1;
            if (i == 11 && ack_low) dev_dat_low = 1'b1;
            if (hold_last && i == nfalls) begin
                repeat (4) @(negedge CLOCK_50);
                return;
            end
            repeat (7) @(negedge CLOCK_50);
            if (i <= 10) fr[i] = ps2_dat;
            if (i == 10) dev_frame = fr;
            dev_clk_low = 1'b0;
            @(negedge CLOCK_50);
            dev_dat_low = 1'b0;
            if (i < nfalls) repeat (6) @(negedge CLOCK_50);
        end
    endtask

    // Monitor: pops and compares on every done pulse.
    initial begin : monitor
        exp_t e;
        bit post_chk;
        post_chk = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (post_chk) begin
                post_chk = 1'b0;
                chk("ready_after_done", tx_ready, 1);
                chk("inhibit_after_done", rx_inhibit, 0);
                chk("done_one_cycle", done, 0);
            end
            if (reset === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 err=%0b expected no done", err);
                end else begin
                    e = exp_q.pop_front();
                    $display("done data=%02h err=%0b frame=%03h", e.data, err, dev_frame);
                    chk("done_err", err, e.err);
                    if (e.chk_frame) chk("frame_bits", dev_frame, e.frame);
                    chk("clk_released", ps2_clk, 1);
                    chk("dat_released", ps2_dat, 1);
                    chk("ready_low_at_done", tx_ready, 0);
                    chk("inhibit_at_done", rx_inhibit, 1);
                    post_chk = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] cmd_leds, cmd_rst, cmd_en;
        int n;
        cmd_leds = ps2_pkg::CMD_SET_LEDS;
        cmd_rst  = ps2_pkg::CMD_RESET;
        cmd_en   = ps2_pkg::CMD_ENABLE;

        repeat (3) @(negedge CLOCK_50);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 2'b00);
        chk("rst_rx_inhibit", rx_inhibit, 0);
        chk("rst_clk_z", ps2_clk, 1);
        chk("rst_dat_z", ps2_dat, 1);
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // 0xED with ACK: frame 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
        issue(cmd_leds, 1'b1, 2'b00, 1'b1, 1'b1);
        dev_run(11, 1'b1, 1'b0);

        // 0x00 (parity 1) with tx_valid held, then 0x01 (parity 0) taken only in IDLE.
        @(negedge CLOCK_50);
        wait_ready();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        push_exp(8'h00, 1'b1, 2'b00, 1'b1);
        @(negedge CLOCK_50);
        tx_data = 8'h01;
        push_exp(8'h01, 1'b0, 2'b00, 1'b1);
        dev_run(11, 1'b1, 1'b0);
        fork
            dev_run(11, 1'b1, 1'b0);
            begin
                n = 0;
                while (tx_ready !== 1'b1 && n < 500) begin
                    @(negedge CLOCK_50);
                    n++;
                end
                @(negedge CLOCK_50);
                tx_valid = 1'b0;
            end
        join

        // Device never clocks: start timeout.
        issue(cmd_en, 1'b0, 2'b01, 1'b0, 1'b1);
        dev_run(0, 1'b0, 1'b0);

        // Device stops after 5 falls: transfer timeout.
        issue(cmd_rst, 1'b1, 2'b10, 1'b0, 1'b1);
        dev_run(5, 1'b0, 1'b0);

        // No ACK, then an immediate re-send of 0xFF.
        issue(cmd_leds, 1'b1, 2'b11, 1'b1, 1'b1);
        dev_run(11, 1'b0, 1'b0);
        issue(cmd_rst, 1'b1, 2'b00, 1'b1, 1'b1);
        dev_run(11, 1'b1, 1'b0);

        // Reset mid-transfer at fall 4 (bit3 of 0xF4 is 0, so DAT is driven low).
        issue(cmd_en, 1'b0, 2'b00, 1'b0, 1'b0);
        dev_run(4, 1'b0, 1'b1);
        chk("bit3_driven_low", ps2_dat, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_dat_release", ps2_dat, 1);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_rx_inhibit", rx_inhibit, 0);
        chk("reset_done", done, 0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        chk("post_reset_clk", ps2_clk, 1);
        chk("post_reset_dat", ps2_dat, 1);
        chk("post_reset_ready", tx_ready, 1);

        repeat (10) @(negedge CLOCK_50);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
